// File: rtl/sram_model_pkg.sv
// Shared constants and the byte-lane merge helper for the 1RW+1R SRAM behavioural model.
// Consumed by sram_1rw1r_model; the SRAM_MODEL_BYPASS_EN option lives in that file.
package sram_model_pkg;

    localparam int unsigned RdLatMin     = 1;
    localparam int unsigned RdLatMax     = 4;
    localparam int unsigned MaxDataWidth = 256;
    localparam int unsigned MaxIdxW      = $clog2(MaxDataWidth);

    typedef logic [MaxDataWidth-1:0] word_t;
    typedef logic [MaxDataWidth-1:0] mask_t;

    // Lanes whose mask bit is set take new_word; all other bits keep old_word.
    function automatic word_t lane_merge(input word_t       old_word,
                                         input word_t       new_word,
                                         input mask_t       mask,
                                         input int unsigned lane_bits);
        word_t                res;
        logic [MaxIdxW-1:0]   lane;
        int unsigned          div;
        res = old_word;
        div = (lane_bits == 0) ? 1 : lane_bits;
        for (int unsigned i = 0; i < MaxDataWidth; i++) begin
            lane = MaxIdxW'(i / div);
            if (mask[lane]) begin
                res[MaxIdxW'(i)] = new_word[MaxIdxW'(i)];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-data delay line: DEPTH register stages carrying a valid bit and data.
// Data stages only load on a valid input, so the output holds between pulses.
module sram_rd_pipe #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 1
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic [DEPTH-1:0]      vld_q;
    logic [DATA_WIDTH-1:0] dat_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!rstb) begin
            vld_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= in_valid;
            if (in_valid) begin
                dat_q[0] <= in_data;
            end
            for (int unsigned i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    assign out_valid = vld_q[DEPTH-1];
    assign out_data  = dat_q[DEPTH-1];

endmodule

// File: rtl/sram_1rw1r_model.sv
// Behavioural 1RW + 1R SRAM with masked writes, pipelined reads and collision flagging.
// Define SRAM_MODEL_BYPASS_EN to forward same-cycle write data to a colliding port-1 read.
module sram_1rw1r_model
    import sram_model_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned NUM_WORDS    = 1 << ADDR_WIDTH,
    parameter int unsigned WMASK_WIDTH  = 4,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rstb,
    input  logic                   csb0,
    input  logic                   web0,
    input  logic [WMASK_WIDTH-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0]  addr0,
    input  logic [DATA_WIDTH-1:0]  din0,
    output logic [DATA_WIDTH-1:0]  dout0,
    output logic                   dvalid0,
    input  logic                   csb1,
    input  logic [ADDR_WIDTH-1:0]  addr1,
    output logic [DATA_WIDTH-1:0]  dout1,
    output logic                   dvalid1,
    output logic                   collision
);

    localparam int unsigned LaneBits = (WMASK_WIDTH == 0) ? 1 : DATA_WIDTH / WMASK_WIDTH;
    localparam int unsigned IdxW     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [ADDR_WIDTH:0] NumWordsA = (ADDR_WIDTH + 1)'(NUM_WORDS);

    if (WMASK_WIDTH == 0 || (DATA_WIDTH % WMASK_WIDTH) != 0) begin : g_bad_mask
        $fatal(1, "DATA_WIDTH must be divisible by WMASK_WIDTH");
    end
    if (READ_LATENCY < RdLatMin || READ_LATENCY > RdLatMax) begin : g_bad_lat
        $fatal(1, "READ_LATENCY out of range");
    end
    if (NUM_WORDS < 2 || NUM_WORDS > (1 << ADDR_WIDTH)) begin : g_bad_words
        $fatal(1, "NUM_WORDS out of range");
    end
    if (DATA_WIDTH > MaxDataWidth) begin : g_bad_width
        $fatal(1, "DATA_WIDTH exceeds package limit");
    end

    logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

    logic                  addr0_ok, addr1_ok;
    logic                  wr_en, rd0_req, rd1_req, collide;
    logic [IdxW-1:0]       idx0, idx1;
    logic [DATA_WIDTH-1:0] old0, old1, fwd_data, wr_data, rd1_data;
    word_t                 wr_full, rd1_full;
    mask_t                 lane_mask;
    logic                  collision_q;

    assign addr0_ok = {1'b0, addr0} < NumWordsA;
    assign addr1_ok = {1'b0, addr1} < NumWordsA;
    assign idx0     = addr0[IdxW-1:0];
    assign idx1     = addr1[IdxW-1:0];

    assign wr_en    = rstb & ~csb0 & ~web0 & addr0_ok;
    assign rd0_req  = rstb & ~csb0 & web0;
    assign rd1_req  = rstb & ~csb1;
    assign collide  = wr_en & rd1_req & (addr0 == addr1);

`ifdef SRAM_MODEL_BYPASS_EN
    assign fwd_data = din0;
`else
    assign fwd_data = 'x;
`endif

    always_comb begin
        old0      = addr0_ok ? mem[idx0] : '0;
        old1      = addr1_ok ? mem[idx1] : '0;
        lane_mask = mask_t'(wmask0);
        wr_full   = lane_merge(word_t'(old0), word_t'(din0), lane_mask, LaneBits);
        rd1_full  = lane_merge(word_t'(old1), word_t'(fwd_data), lane_mask, LaneBits);
        wr_data   = wr_full[DATA_WIDTH-1:0];
        rd1_data  = collide ? rd1_full[DATA_WIDTH-1:0] : old1;
    end

    // Upper bits of the package-wide merge word are don't-care at this width.
    if (DATA_WIDTH < MaxDataWidth) begin : g_unused
        logic unused_merge;
        assign unused_merge = ^{wr_full[MaxDataWidth-1:DATA_WIDTH],
                                rd1_full[MaxDataWidth-1:DATA_WIDTH]};
    end

    // Memory has no reset; wr_en already excludes reset cycles.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[idx0] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            collision_q <= 1'b0;
        end else begin
            collision_q <= collide;
        end
    end

    assign collision = collision_q;

    sram_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (READ_LATENCY)
    ) u_rd_pipe0 (
        .clk       (clk),
        .rstb      (rstb),
        .in_valid  (rd0_req),
        .in_data   (old0),
        .out_valid (dvalid0),
        .out_data  (dout0)
    );

    sram_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (READ_LATENCY)
    ) u_rd_pipe1 (
        .clk       (clk),
        .rstb      (rstb),
        .in_valid  (rd1_req),
        .in_data   (rd1_data),
        .out_valid (dvalid1),
        .out_data  (dout1)
    );

endmodule

// File: tb/tb_sram_1rw1r_model.sv
// Scoreboard bench for sram_1rw1r_model: directed vectors push expectations, a negedge
// monitor pops them on dvalid/collision and also checks hold and reset behaviour.
module tb_sram_1rw1r_model;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rstb, csb0, web0, csb1;
    logic [3:0]  wmask0;
    logic [7:0]  addr0, addr1;
    logic [31:0] din0, dout0, dout1;
    logic        dvalid0, dvalid1, collision;

    sram_1rw1r_model #(
        .DATA_WIDTH   (32),
        .ADDR_WIDTH   (8),
        .NUM_WORDS    (200),
        .WMASK_WIDTH  (4),
        .READ_LATENCY (LAT)
    ) dut (
        .clk       (clk),
        .rstb      (rstb),
        .csb0      (csb0),
        .web0      (web0),
        .wmask0    (wmask0),
        .addr0     (addr0),
        .din0      (din0),
        .dout0     (dout0),
        .dvalid0   (dvalid0),
        .csb1      (csb1),
        .addr1     (addr1),
        .dout1     (dout1),
        .dvalid1   (dvalid1),
        .collision (collision)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [31:0] care;
        int          due;
    } exp_t;

    localparam logic [31:0] All = 32'hFFFF_FFFF;
`ifdef SRAM_MODEL_BYPASS_EN
    localparam logic [31:0] ColCareFull = 32'hFFFF_FFFF;
    localparam logic [31:0] ColCarePart = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] ColCareFull = 32'h0000_0000;
    localparam logic [31:0] ColCarePart = 32'hFFFF_0000;
`endif

    exp_t q0[$];
    exp_t q1[$];
    int   colq[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    logic rst_seen = 1'b0;
    exp_t hold0 = '{32'h0, 32'hFFFF_FFFF, 0};
    exp_t hold1 = '{32'h0, 32'hFFFF_FFFF, 0};

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= !rstb;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp,
                       input logic [31:0] care);
        checks++;
        if (((act ^ exp) & care) !== 32'h0) begin
            errors++;
            $display("FAIL %s: got %h expected %h (care %h) at cycle %0d",
                     name, act, exp, care, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        bit   exp_col;
        if (mon_en) begin
            if (rst_seen) begin
                chk("dvalid0_rst", 32'(dvalid0), 32'd0, All);
                chk("dout0_rst", dout0, 32'd0, All);
                chk("dvalid1_rst", 32'(dvalid1), 32'd0, All);
                chk("dout1_rst", dout1, 32'd0, All);
                chk("collision_rst", 32'(collision), 32'd0, All);
                hold0 = '{32'h0, All, 0};
                hold1 = '{32'h0, All, 0};
            end else begin
                while (q0.size() > 0 && q0[0].due < cyc) begin
                    chk("dvalid0_missing", 32'd0, 32'd1, All);
                    void'(q0.pop_front());
                end
                if (dvalid0) begin
                    if (q0.size() == 0 || q0[0].due != cyc) begin
                        chk("dvalid0_unexpected", 32'd1, 32'd0, All);
                    end else begin
                        e = q0.pop_front();
                        chk("dout0", dout0, e.data, e.care);
                        hold0 = e;
                    end
                end else begin
                    chk("dout0_hold", dout0, hold0.data, hold0.care);
                end

                while (q1.size() > 0 && q1[0].due < cyc) begin
                    chk("dvalid1_missing", 32'd0, 32'd1, All);
                    void'(q1.pop_front());
                end
                if (dvalid1) begin
                    if (q1.size() == 0 || q1[0].due != cyc) begin
                        chk("dvalid1_unexpected", 32'd1, 32'd0, All);
                    end else begin
                        e = q1.pop_front();
                        chk("dout1", dout1, e.data, e.care);
                        hold1 = e;
                    end
                end else begin
                    chk("dout1_hold", dout1, hold1.data, hold1.care);
                end

                exp_col = (colq.size() > 0 && colq[0] == cyc);
                if (exp_col) void'(colq.pop_front());
                chk("collision", 32'(collision), 32'(exp_col), All);
            end
        end
    end

    // One cycle of stimulus; expectations are pushed as the request is issued.
    task automatic op(input bit p0, input bit we, input logic [7:0] a0, input logic [31:0] d0,
                      input logic [3:0] m0, input logic [31:0] e0, input bit p1,
                      input logic [7:0] a1, input logic [31:0] e1, input logic [31:0] c1,
                      input bit col);
        csb0   = !p0;
        web0   = !we;
        addr0  = a0;
        din0   = d0;
        wmask0 = m0;
        csb1   = !p1;
        addr1  = a1;
        if (p0 && !we) q0.push_back('{e0, All, cyc + LAT});
        if (p1) q1.push_back('{e1, c1, cyc + LAT});
        if (col) colq.push_back(cyc + 1);
        @(negedge clk);
        csb0   = 1'b1;
        web0   = 1'b1;
        csb1   = 1'b1;
        wmask0 = 4'h0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
        op(1, 1, a, d, m, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rd0(input logic [7:0] a, input logic [31:0] e);
        op(1, 0, a, 0, 0, e, 0, 0, 0, 0, 0);
    endtask

    task automatic rd1(input logic [7:0] a, input logic [31:0] e);
        op(0, 0, 0, 0, 0, 0, 1, a, e, All, 0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rstb = 1'b0; csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1;
        wmask0 = 4'h0; addr0 = 8'h0; addr1 = 8'h0; din0 = 32'h0;
        idle(3);
        mon_en = 1'b1;
        idle(1);
        rstb = 1'b1;

        // Preload
        wr(8'd0, 32'h0000_1000, 4'hF);
        wr(8'd1, 32'h1111_2222, 4'hF);
        wr(8'd2, 32'h2222_3333, 4'hF);
        wr(8'd7, 32'h0000_0000, 4'hF);

        // Full write then port-1 read next cycle
        wr(8'd3, 32'hA5A5_A5A5, 4'hF);
        rd1(8'd3, 32'hA5A5_A5A5);

        // Partial lane write
        wr(8'd5, 32'h1122_3344, 4'hF);
        wr(8'd5, 32'hFFFF_FFFF, 4'b0101);
        op(1, 0, 8'd5, 0, 0, 32'h11FF_33FF, 1, 8'd5, 32'h11FF_33FF, All, 0);

        // Collisions: full-mask and partial-mask
        op(1, 1, 8'd7, 32'hDEAD_BEEF, 4'hF, 0, 1, 8'd7, 32'hDEAD_BEEF, ColCareFull, 1);
        rd1(8'd7, 32'hDEAD_BEEF);
        op(1, 1, 8'd5, 32'hAABB_CCDD, 4'b0011, 0, 1, 8'd5, 32'h11FF_CCDD, ColCarePart, 1);
        rd0(8'd5, 32'h11FF_CCDD);

        // Write and read to different addresses: no collision
        op(1, 1, 8'd9, 32'h0BAD_F00D, 4'hF, 0, 1, 8'd3, 32'hA5A5_A5A5, All, 0);
        rd0(8'd9, 32'h0BAD_F00D);

        // Out-of-range write ignored, out-of-range reads return zero
        wr(8'd250, 32'h1234_5678, 4'hF);
        rd0(8'd250, 32'h0);
        rd1(8'd250, 32'h0);
        rd1(8'd3, 32'hA5A5_A5A5);

        // Back-to-back reads on both ports
        op(1, 0, 8'd0, 0, 0, 32'h0000_1000, 1, 8'd3, 32'hA5A5_A5A5, All, 0);
        op(1, 0, 8'd1, 0, 0, 32'h1111_2222, 1, 8'd2, 32'h2222_3333, All, 0);
        op(1, 0, 8'd2, 0, 0, 32'h2222_3333, 1, 8'd1, 32'h1111_2222, All, 0);
        op(1, 0, 8'd3, 0, 0, 32'hA5A5_A5A5, 1, 8'd0, 32'h0000_1000, All, 0);
        idle(LAT + 2);

        // Read in flight when reset asserts is dropped; traffic during reset ignored
        csb0 = 1'b0; web0 = 1'b1; addr0 = 8'd1;
        @(negedge clk);
        rstb = 1'b0;
        csb0 = 1'b0; web0 = 1'b0; addr0 = 8'd2; din0 = 32'hFFFF_FFFF; wmask0 = 4'hF;
        csb1 = 1'b0; addr1 = 8'd2;
        idle(3);
        rstb = 1'b1;
        csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1; wmask0 = 4'h0;
        idle(LAT + 2);
        rd0(8'd1, 32'h1111_2222);
        rd1(8'd2, 32'h2222_3333);
        idle(LAT + 3);

        chk("q0_drained", 32'(q0.size()), 32'd0, All);
        chk("q1_drained", 32'(q1.size()), 32'd0, All);
        chk("colq_drained", 32'(colq.size()), 32'd0, All);
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_1rw1r_model.md
SRAM_1RW1R_MODEL -- requirements
Module: sram_1rw1r_model

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, address width.
REQ-003 SHALL have parameter NUM_WORDS, default 1<<ADDR_WIDTH, number of implemented words (2..1<<ADDR_WIDTH).
REQ-004 SHALL have parameter WMASK_WIDTH, default 4, write-mask lanes; DATA_WIDTH divisible by WMASK_WIDTH.
REQ-005 SHALL have parameter READ_LATENCY, default 1, read pipeline depth, legal range 1..4.
REQ-006 SHALL have port clk, input, 1, single clock; all state changes on posedge.
REQ-007 SHALL have port rstb, input, 1, synchronous active-low reset.
REQ-008 SHALL have port csb0, input, 1, port-0 active-low select.
REQ-009 SHALL have port web0, input, 1, port-0 active-low write enable.
REQ-010 SHALL have port wmask0, input, WMASK_WIDTH, per-lane write enable, active high.
REQ-011 SHALL have port addr0, input, ADDR_WIDTH, port-0 address.
REQ-012 SHALL have port din0, input, DATA_WIDTH, port-0 write data.
REQ-013 SHALL have port dout0, output, DATA_WIDTH, port-0 read data.
REQ-014 SHALL have port dvalid0, output, 1, one-cycle pulse marking new dout0.
REQ-015 SHALL have port csb1, input, 1, port-1 (read-only) active-low select.
REQ-016 SHALL have port addr1, input, ADDR_WIDTH, port-1 address.
REQ-017 SHALL have port dout1, output, DATA_WIDTH, port-1 read data.
REQ-018 SHALL have port dvalid1, output, 1, one-cycle pulse marking new dout1.
REQ-019 SHALL have port collision, output, 1, one-cycle pulse: same-cycle port-0 write and port-1 read to one address.

Function
REQ-020 Write SHALL occur at posedge when rstb=1, csb0=0, web0=0, addr0<NUM_WORDS; only lanes with wmask0[i]=1 updated.
REQ-021 Write with addr0>=NUM_WORDS SHALL be ignored; memory unchanged.
REQ-022 Port-0 read SHALL be accepted at posedge when rstb=1, csb0=0, web0=1; port-1 read when rstb=1, csb1=0.
REQ-023 Read data SHALL appear on doutN exactly READ_LATENCY cycles after the accepting edge, with dvalidN=1 for that one cycle.
REQ-024 Reads SHALL be fully pipelined: one new request per port per cycle, no stalls, results in request order.
REQ-025 doutN SHALL hold its last value while dvalidN=0.
REQ-026 Read with address>=NUM_WORDS SHALL return all-zero data with dvalidN=1.
REQ-027 Port-0 read SHALL return contents before any same-cycle write (none possible on port 0 in the same cycle anyway).
REQ-028 Port-1 read to an address written by port 0 in the same cycle SHALL pulse collision in the cycle after the edge, independent of READ_LATENCY.
REQ-029 Collision data behaviour SHALL be per REQ-034/REQ-035; unwritten lanes always return old data.
REQ-030 Port-1 read to a different address than a same-cycle write SHALL return stored data with no collision.

Reset
REQ-031 While rstb=0 at posedge: dout0, dout1 SHALL be 0; dvalid0, dvalid1, collision SHALL be 0; all read pipeline stages SHALL be cleared.
REQ-032 Reset SHALL NOT alter memory contents; writes and reads presented during reset SHALL be ignored.
REQ-033 Reads in flight when reset asserts SHALL be discarded; no dvalid pulse for them after release.

Configuration
REQ-034 With SRAM_MODEL_BYPASS_EN defined, colliding port-1 read SHALL return new data in written lanes (write-through forwarding).
REQ-035 Without SRAM_MODEL_BYPASS_EN, colliding port-1 read SHALL return X in written lanes.

Structure
REQ-036 Package sram_model_pkg SHALL hold READ_LATENCY min/max constants and the lane-merge function (old, new, mask).
REQ-037 Sub-module sram_rd_pipe SHALL implement the data+valid delay line of depth READ_LATENCY with synchronous clear; instantiated once per port.
REQ-038 Parameter legality (divisibility, latency range, NUM_WORDS range) SHALL be checked at elaboration with a fatal error.

Verification
REQ-039 Write 0xA5A5A5A5 to addr 3, mask 4'b1111; port-1 read addr 3 next cycle, READ_LATENCY=2 -> dout1=0xA5A5A5A5, dvalid1 high exactly 2 cycles after request.
REQ-040 Addr 5 holds 0x11223344; write 0xFFFFFFFF mask 4'b0101 -> read returns 0x11FF33FF.
REQ-041 Same-cycle port-0 write 0xDEADBEEF and port-1 read to addr 7 (old 0) -> collision pulse; dout1=0xDEADBEEF with SRAM_MODEL_BYPASS_EN, X without.
REQ-042 NUM_WORDS=200: write addr 250, then read addr 250 -> dout=0, dvalid=1, no memory word changed.
REQ-043 Back-to-back port-0 reads of addrs 0,1,2,3 at READ_LATENCY=3 -> four consecutive dvalid0 pulses, data in order.
REQ-044 Issue read, assert rstb=0 one cycle later -> no dvalid pulse, outputs 0; memory retains pre-reset data on subsequent read.
